// File: rtl/duty_code_recover.sv
// Receiver for the serial duty-pattern stream: frames bits on frame_sync, checks each
// frame is a leading-ones thermometer and recovers code = ones - 1.
module duty_code_recover #(
   parameter int FRAME_LEN = 8,
   parameter int CW        = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ser_in,
   input  logic          frame_sync,
   output logic [CW-1:0] code,
   output logic          code_valid,
   output logic          pattern_err,
   output logic          sync_err,
   output logic          locked
);

   typedef enum logic {IDLE, COLLECT} state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   state_t        state_q;
   logic [CW-1:0] idx_q;
   logic [CW:0]   ones_q;
   logic          seen0_q;
   logic          bad_q;
   logic [CW-1:0] code_q;
   logic          code_valid_q;
   logic          pattern_err_q;
   logic          sync_err_q;
   logic          locked_q;

   logic [CW:0]   ones_d;
   logic          seen0_d;
   logic          bad_d;
   logic [CW-1:0] code_d;
   logic          good_d;

   // Frame statistics including the bit on ser_in this cycle, so the frame end
   // can be judged on the same edge that samples its last bit.
   always_comb begin
      ones_d  = ones_q + {{CW{1'b0}}, ser_in};
      seen0_d = seen0_q | ~ser_in;
      bad_d   = bad_q | (ser_in & seen0_q);
      code_d  = ones_d[CW-1:0] - CW'(1);
      good_d  = (ones_d != '0) && !bad_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         ones_q        <= '0;
         seen0_q       <= 1'b0;
         bad_q         <= 1'b0;
         code_q        <= '0;
         code_valid_q  <= 1'b0;
         pattern_err_q <= 1'b0;
         sync_err_q    <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         code_valid_q  <= 1'b0;
         pattern_err_q <= 1'b0;
         sync_err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (frame_sync) begin
                  state_q <= COLLECT;
                  idx_q   <= CW'(1);
                  ones_q  <= {{CW{1'b0}}, ser_in};
                  seen0_q <= ~ser_in;
                  bad_q   <= 1'b0;
               end
            end
            COLLECT: begin
               if (frame_sync && idx_q != '0) begin
                  // Early sync: this bit becomes bit 0 of a fresh frame.
                  sync_err_q <= 1'b1;
                  locked_q   <= 1'b0;
                  idx_q      <= CW'(1);
                  ones_q     <= {{CW{1'b0}}, ser_in};
                  seen0_q    <= ~ser_in;
                  bad_q      <= 1'b0;
               end else if (idx_q == '0) begin
                  if (frame_sync) begin
                     idx_q   <= CW'(1);
                     ones_q  <= {{CW{1'b0}}, ser_in};
                     seen0_q <= ~ser_in;
                     bad_q   <= 1'b0;
                  end else begin
                     sync_err_q <= 1'b1;
                     locked_q   <= 1'b0;
                     state_q    <= IDLE;
                  end
               end else begin
                  ones_q  <= ones_d;
                  seen0_q <= seen0_d;
                  bad_q   <= bad_d;
                  idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + CW'(1);
                  if (idx_q == LAST_IDX) begin
                     if (good_d) begin
                        code_q       <= code_d;
                        code_valid_q <= 1'b1;
                        locked_q     <= 1'b1;
                     end else begin
                        pattern_err_q <= 1'b1;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign code        = code_q;
   assign code_valid  = code_valid_q;
   assign pattern_err = pattern_err_q;
   assign sync_err    = sync_err_q;
   assign locked      = locked_q;

endmodule
